// File: rtl/avg_down_pkg.sv
// avg_down_pkg: shared widths, state encoding and the round/shift helper for avg_down_n.
package avg_down_pkg;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic int ACC_W(input int n, input int m);
    return n + m;
  endfunction
  function automatic int KW(input int m);
    return $clog2(m + 1);
  endfunction
  // sum arrives already sign/zero-extended to 64 bits, so the rounding add cannot wrap
  function automatic logic [63:0] round_shift(input logic [63:0] sum, input int k,
                                              input logic rnd, input logic sgn);
    logic [63:0] t;
    t = sum + ((rnd && k > 0) ? (64'd1 << (k - 1)) : 64'd0);
    return sgn ? 64'($signed(t) >>> k) : t >> k;
  endfunction
endpackage

// File: rtl/avg_down_n_acc.sv
// avg_down_n_acc: block accumulator, sample counter and per-block k latch.
module avg_down_n_acc import avg_down_pkg::*; #(
  parameter int N        = 14,
  parameter int MAX_LOG2 = 4,
  parameter int SIGNED   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ready_i,
  input  logic                            clr_i,
  input  logic [N-1:0]                    x_i,
  input  logic [KW(MAX_LOG2)-1:0]         log2_dec_i,
  output logic [ACC_W(N,MAX_LOG2)-1:0]    sum_o,
  output logic [KW(MAX_LOG2)-1:0]         k_o,
  output logic                            last_o,
  output logic                            busy_o
);
  localparam int AW = ACC_W(N, MAX_LOG2);
  localparam int KB = KW(MAX_LOG2);
  localparam int CW = MAX_LOG2 > 0 ? MAX_LOG2 : 1;
  state_e         state_q, state_d;
  logic [AW-1:0]  acc_q, acc_d, x_ext;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KB-1:0]  k_q, k_d, k_clamp;
  logic           accept;
  assign x_ext   = {{MAX_LOG2{(SIGNED != 0) && x_i[N-1]}}, x_i};
  assign k_clamp = log2_dec_i > KB'(MAX_LOG2) ? KB'(MAX_LOG2) : log2_dec_i;
  // the first sample of a block already uses the freshly latched k
  assign k_o     = state_q == IDLE ? k_clamp : k_q;
  assign accept  = ready_i && !clr_i;
  assign sum_o   = acc_q + x_ext;
  assign last_o  = accept && (cnt_q == CW'((32'd1 << k_o) - 32'd1));
  assign busy_o  = state_q == ACCUM;
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    state_d = state_q;
    if (clr_i || last_o) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (accept) begin
      acc_d   = sum_o;
      cnt_d   = cnt_q + 1'b1;
      state_d = ACCUM;
    end
    if (accept && state_q == IDLE) k_d = k_clamp;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      state_q <= IDLE;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      state_q <= state_d;
    end
endmodule

// File: rtl/avg_down_n.sv
// avg_down_n: decimating boxcar averager over 2^k strobed samples with truncate or round-half-up.
module avg_down_n import avg_down_pkg::*; #(
  parameter int N        = 14,
  parameter int MAX_LOG2 = 4,
  parameter int SIGNED   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic [N-1:0]             x,
  input  logic [KW(MAX_LOG2)-1:0]  log2_dec,
  input  logic                     round_en,
  input  logic                     clr,
  output logic [N-1:0]             y,
  output logic                     valid,
  output logic                     busy
);
  localparam int AW = ACC_W(N, MAX_LOG2);
  logic [AW-1:0]            sum;
  logic [KW(MAX_LOG2)-1:0]  k;
  logic                     last;
  logic [63:0]              sum_ext;
  logic [N-1:0]             y_q, y_d;
  logic                     valid_q;
  avg_down_n_acc #(.N(N), .MAX_LOG2(MAX_LOG2), .SIGNED(SIGNED)) u_acc (
    .clk(clk), .rst(rst), .ready_i(ready), .clr_i(clr), .x_i(x),
    .log2_dec_i(log2_dec), .sum_o(sum), .k_o(k), .last_o(last), .busy_o(busy)
  );
  assign sum_ext = {{(64-AW){(SIGNED != 0) && sum[AW-1]}}, sum};
  assign y_d     = last ? N'(round_shift(sum_ext, int'(k), round_en, SIGNED != 0)) : y_q;
  assign y       = y_q;
  assign valid   = valid_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= last;
    end
endmodule

// File: tb/tb_avg_down_n.sv
// tb_avg_down_n: directed checks of avg_down_n, unsigned and signed instances sharing stimulus.
module tb_avg_down_n;
  logic        clk = 0, rst = 1, ready = 0, round_en = 0, clr = 0;
  logic [13:0] x = '0;
  logic [2:0]  log2_dec = '0;
  logic [13:0] y, ys;
  logic        valid, busy, valid_s, busy_s;
  int          n_run = 0, n_fail = 0;
  avg_down_n #(.N(14), .MAX_LOG2(4), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .ready(ready), .x(x), .log2_dec(log2_dec),
    .round_en(round_en), .clr(clr), .y(y), .valid(valid), .busy(busy));
  avg_down_n #(.N(14), .MAX_LOG2(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .ready(ready), .x(x), .log2_dec(log2_dec),
    .round_en(round_en), .clr(clr), .y(ys), .valid(valid_s), .busy(busy_s));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [13:0] v);
    ready = 1;
    x = v;
    @(negedge clk);
    ready = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_y", y, 0); chk("rst_valid", valid, 0); chk("rst_busy", busy, 0);
    rst = 0;
    log2_dec = 1;
    send(127);
    chk("k1_busy_mid", busy, 1); chk("k1_valid_mid", valid, 0);
    @(negedge clk);
    chk("k1_busy_gap", busy, 1);
    send(7);
    chk("k1_valid", valid, 1); chk("k1_y", y, 67);
    @(negedge clk);
    chk("k1_valid_drop", valid, 0); chk("k1_busy_end", busy, 0);
    round_en = 1; send(112); send(63);
    chk("k1_round_y", y, 88); chk("k1_round_v", valid, 1);
    round_en = 0; send(112); send(63);
    chk("k1_trunc_y", y, 87);
    log2_dec = 2;
    for (int m = 0; m < 2; m++) begin
      round_en = m[0];
      repeat (4) send(14'h3FFF);
      chk(m ? "k2_max_round" : "k2_max_trunc", y, 16383);
    end
    round_en = 0;
    log2_dec = 0;
    send(5); chk("k0_y5", y, 5); chk("k0_v5", valid, 1); chk("k0_busy", busy, 0);
    send(9); chk("k0_y9", y, 9); chk("k0_v9", valid, 1);
    ready = 1; x = 1; @(negedge clk);
    chk("b2b_v1", valid, 1); chk("b2b_y1", y, 1);
    x = 2; @(negedge clk);
    chk("b2b_v2", valid, 1); chk("b2b_y2", y, 2);
    ready = 0;
    log2_dec = 2;
    send(100); send(200);
    rst = 1; @(negedge clk);
    chk("mrst_y", y, 0); chk("mrst_valid", valid, 0); chk("mrst_busy", busy, 0);
    rst = 0;
    send(4); send(8); send(12); send(16);
    chk("post_rst_y", y, 10); chk("post_rst_v", valid, 1);
    send(1); log2_dec = 1; send(3);
    chk("klatch_no_early", valid, 0);
    send(5); send(7);
    chk("klatch_y", y, 4); chk("klatch_v", valid, 1);
    log2_dec = 7;
    for (int i = 0; i < 16; i++) begin
      send(14'(i));
      chk($sformatf("clamp_v%0d", i), valid, i == 15);
    end
    chk("clamp_y", y, 7);
    log2_dec = 2;
    send(50); send(50); send(50);
    ready = 1; clr = 1; x = 999; @(negedge clk);
    ready = 0; clr = 0;
    chk("clr_busy", busy, 0); chk("clr_valid", valid, 0); chk("clr_y_hold", y, 7);
    send(20); send(20); send(20); send(24);
    chk("post_clr_y", y, 21); chk("post_clr_v", valid, 1);
    log2_dec = 1; round_en = 0;
    send(14'h3FFD); send(2);
    chk("s_trunc_y", ys, 14'h3FFF); chk("s_trunc_v", valid_s, 1); chk("u_trunc_y", y, 8191);
    round_en = 1;
    send(14'h3FFD); send(2);
    chk("s_round_y", ys, 0); chk("u_round_y", y, 8192);
    round_en = 0;
    send(14'h2000); send(14'h2000);
    chk("s_min_y", ys, 14'h2000); chk("s_min_busy", busy_s, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
